rom_fetch_arbiter: RTL and testbench

ROM_FETCH_ARBITER -- requirements
Module: rom_fetch_arbiter

---
 rtl/rom_fetch_arbiter_if.sv | 33 +++
 rtl/rom_fetch_arbiter.sv | 114 +++++++++++
 tb/tb_rom_fetch_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_fetch_arbiter_if.sv
// Bus bundle between the ROM fetch arbiter, its two requesters (CPU and debug)
// and the combinational instruction ROM. The arbiter takes the slave view.
interface rom_fetch_arbiter_if;
    logic        iCpuReq;
    logic [15:0] iCpuAddress;
    logic        oCpuGrant;
    logic        oCpuValid;
    logic [27:0] oCpuInstruction;

    logic        iDbgReq;
    logic [15:0] iDbgAddress;
    logic        oDbgGrant;
    logic        oDbgValid;
    logic [27:0] oDbgInstruction;
    logic        oDbgDone;

    logic [15:0] oRomAddress;
    logic [27:0] iRomInstruction;

    modport slave (
        input  iCpuReq, iCpuAddress, iDbgReq, iDbgAddress, iRomInstruction,
        output oCpuGrant, oCpuValid, oCpuInstruction,
        output oDbgGrant, oDbgValid, oDbgInstruction, oDbgDone,
        output oRomAddress
    );

    modport master (
        output iCpuReq, iCpuAddress, iDbgReq, iDbgAddress, iRomInstruction,
        input  oCpuGrant, oCpuValid, oCpuInstruction,
        input  oDbgGrant, oDbgValid, oDbgInstruction, oDbgDone,
        input  oRomAddress
    );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// Arbitrates a single-ported combinational instruction ROM between CPU fetches
// and debug burst reads. CPU has priority, but once it has been granted
// MAX_CPU_RUN times in a row while debug waits, debug takes the next slot and
// then owns the ROM for a DBG_BURST-word burst. Read data is registered, so
// every access returns its data one cycle after the grant.
module rom_fetch_arbiter #(
    parameter int DBG_BURST   = 4,
    parameter int MAX_CPU_RUN = 8
) (
    input  logic Clock,
    input  logic Reset,
    rom_fetch_arbiter_if.slave bus
);

    localparam logic [4:0] LAST_BEAT = 5'(DBG_BURST - 1);
    localparam logic [7:0] RUN_LIMIT = 8'(MAX_CPU_RUN);

    typedef enum logic {ST_CPU, ST_DBG} state_t;

    state_t      state;
    logic [7:0]  cpuRun;
    logic [4:0]  beatCnt;
    logic [15:0] burstPtr;
    logic [15:0] lastAddr;
    logic [15:0] romAddress;
    logic        cpuWin;
    logic        dbgWin;
    logic        dbgBeat;
    logic        burstEnd;

    // Pick this cycle's ROM owner and steer the ROM address; with no access the address holds.
    always_comb begin
        dbgBeat    = (state == ST_DBG);
        dbgWin     = !dbgBeat && bus.iDbgReq && (!bus.iCpuReq || cpuRun == RUN_LIMIT);
        cpuWin     = !dbgBeat && !dbgWin && bus.iCpuReq;
        burstEnd   = (dbgWin && DBG_BURST == 1) || (dbgBeat && beatCnt == LAST_BEAT);
        romAddress = lastAddr;
        if (cpuWin) begin
            romAddress = bus.iCpuAddress;
        end else if (dbgWin) begin
            romAddress = bus.iDbgAddress;
        end else if (dbgBeat) begin
            romAddress = burstPtr;
        end
    end

    assign bus.oRomAddress = romAddress;
    assign bus.oCpuGrant   = cpuWin;
    assign bus.oDbgGrant   = dbgWin;

    // Burst sequencer: the grant cycle is beat 1, later beats walk the pointer until DBG_BURST.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_CPU;
            beatCnt  <= 5'd0;
            burstPtr <= 16'd0;
        end else begin
            case (state)
                ST_CPU: begin
                    if (dbgWin) begin
                        burstPtr <= bus.iDbgAddress + 16'd1;
                        beatCnt  <= 5'd1;
                        if (DBG_BURST > 1) begin
                            state <= ST_DBG;
                        end
                    end
                end
                ST_DBG: begin
                    burstPtr <= burstPtr + 16'd1;
                    beatCnt  <= beatCnt + 5'd1;
                    if (beatCnt == LAST_BEAT) begin
                        state <= ST_CPU;
                    end
                end
                default: state <= ST_CPU;
            endcase
        end
    end

    // Count back-to-back CPU wins while debug is waiting so debug cannot be starved.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cpuRun <= 8'd0;
        end else if (dbgWin || !bus.iDbgReq) begin
            cpuRun <= 8'd0;
        end else if (cpuWin && cpuRun != RUN_LIMIT) begin
            cpuRun <= cpuRun + 8'd1;
        end
    end

    // Register ROM data toward whichever side owned the access; data holds when not valid.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            lastAddr            <= 16'd0;
            bus.oCpuValid       <= 1'b0;
            bus.oCpuInstruction <= 28'd0;
            bus.oDbgValid       <= 1'b0;
            bus.oDbgInstruction <= 28'd0;
            bus.oDbgDone        <= 1'b0;
        end else begin
            lastAddr      <= romAddress;
            bus.oCpuValid <= cpuWin;
            bus.oDbgValid <= dbgWin || dbgBeat;
            bus.oDbgDone  <= burstEnd;
            if (cpuWin) begin
                bus.oCpuInstruction <= bus.iRomInstruction;
            end
            if (dbgWin || dbgBeat) begin
                bus.oDbgInstruction <= bus.iRomInstruction;
            end
        end
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter. A transaction-level model tracks
// burst words still owed, the CPU win streak and the last ROM address, and
// predicts grants, ROM address and next-cycle read results every cycle.
// Directed scenarios pin the model with literal expectations; a random phase
// with hold-until-granted requesters follows.
module tb_rom_fetch_arbiter;
    localparam int DBG_BURST   = 4;
    localparam int MAX_CPU_RUN = 8;

    logic Clock;
    logic Reset;

    rom_fetch_arbiter_if bus ();

    rom_fetch_arbiter #(
        .DBG_BURST  (DBG_BURST),
        .MAX_CPU_RUN(MAX_CPU_RUN)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    // Bench ROM: each word is its own address, zero-extended.
    assign bus.iRomInstruction = {12'h000, bus.oRomAddress};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    int          mBurstLeft;
    logic [15:0] mBurstNext;
    logic [15:0] mLastAddr;
    int          mRun;
    logic        eCpuValid, eDbgValid, eDbgDone;
    logic [27:0] eCpuData, eDbgData;
    logic        lastCpuGnt, lastDbgGnt;

    logic [27:0] obsCpu[$];
    logic [27:0] obsDbg[$];
    logic [27:0] obsDone[$];
    int          grantLog[$];
    int          cpuGntCount, dbgGntCount;
    logic [27:0] wantQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkSeq(input string name, input logic [27:0] got[$], input logic [27:0] want[$]);
        checkOutput({name, "_count"}, 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < want.size(); i++) begin
            checkOutput(name, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(want[i]));
        end
    endtask

    task automatic resetModel();
        mBurstLeft = 0;
        mBurstNext = 16'd0;
        mLastAddr  = 16'd0;
        mRun       = 0;
        eCpuValid  = 1'b0;
        eDbgValid  = 1'b0;
        eDbgDone   = 1'b0;
        eCpuData   = 28'd0;
        eDbgData   = 28'd0;
        lastCpuGnt = 1'b0;
        lastDbgGnt = 1'b0;
    endtask

    task automatic clearObs();
        obsCpu.delete();
        obsDbg.delete();
        obsDone.delete();
        grantLog.delete();
        cpuGntCount = 0;
        dbgGntCount = 0;
    endtask

    task automatic checkRegs();
        checkOutput("cpu_valid", 32'(bus.oCpuValid), 32'(eCpuValid));
        checkOutput("cpu_data",  32'(bus.oCpuInstruction), 32'(eCpuData));
        checkOutput("dbg_valid", 32'(bus.oDbgValid), 32'(eDbgValid));
        checkOutput("dbg_data",  32'(bus.oDbgInstruction), 32'(eDbgData));
        checkOutput("dbg_done",  32'(bus.oDbgDone), 32'(eDbgDone));
        checkOutput("valid_exclusive", 32'(bus.oCpuValid && bus.oDbgValid), 32'd0);
        if (bus.oCpuValid) obsCpu.push_back(bus.oCpuInstruction);
        if (bus.oDbgValid) obsDbg.push_back(bus.oDbgInstruction);
        if (bus.oDbgDone)  obsDone.push_back(bus.oDbgInstruction);
    endtask

    // One cycle: check last cycle's results, drive requests, predict and check this cycle.
    task automatic applyStimulus(input logic creq, input logic [15:0] caddr, input logic dreq, input logic [15:0] daddr);
        logic [15:0] addr;
        logic        cg, dg, dacc, dn;
        checkRegs();
        bus.iCpuReq     = creq;
        bus.iCpuAddress = caddr;
        bus.iDbgReq     = dreq;
        bus.iDbgAddress = daddr;
        #1;
        cg = 1'b0; dg = 1'b0; dacc = 1'b0; dn = 1'b0;
        addr = mLastAddr;
        if (mBurstLeft > 0) begin
            addr = mBurstNext;
            mBurstNext = mBurstNext + 16'd1;
            mBurstLeft--;
            dacc = 1'b1;
            dn = (mBurstLeft == 0);
        end else if (dreq && (!creq || mRun == MAX_CPU_RUN)) begin
            dg = 1'b1;
            dacc = 1'b1;
            addr = daddr;
            mBurstNext = daddr + 16'd1;
            mBurstLeft = DBG_BURST - 1;
            dn = (DBG_BURST == 1);
            mRun = 0;
        end else if (creq) begin
            cg = 1'b1;
            addr = caddr;
            if (dreq && mRun < MAX_CPU_RUN) mRun++;
        end
        if (!dreq) mRun = 0;

        checkOutput("cpu_grant", 32'(bus.oCpuGrant), 32'(cg));
        checkOutput("dbg_grant", 32'(bus.oDbgGrant), 32'(dg));
        checkOutput("rom_addr",  32'(bus.oRomAddress), 32'(addr));
        grantLog.push_back(bus.oCpuGrant ? 1 : (bus.oDbgGrant ? 2 : 0));
        if (bus.oCpuGrant) cpuGntCount++;
        if (bus.oDbgGrant) dbgGntCount++;

        mLastAddr = addr;
        eCpuValid = cg;
        if (cg) eCpuData = {12'h000, addr};
        eDbgValid = dacc;
        if (dacc) eDbgData = {12'h000, addr};
        eDbgDone = dn;
        lastCpuGnt = cg;
        lastDbgGnt = dg;
        @(negedge Clock);
    endtask

    // Assert reset (optionally checking pending results first), confirm immediate clear, release.
    task automatic doReset(input logic checkFirst);
        if (checkFirst) checkRegs();
        bus.iCpuReq     = 1'b0;
        bus.iCpuAddress = 16'd0;
        bus.iDbgReq     = 1'b0;
        bus.iDbgAddress = 16'd0;
        Reset = 1'b0;
        #1;
        resetModel();
        checkOutput("rst_cpu_valid", 32'(bus.oCpuValid), 32'd0);
        checkOutput("rst_cpu_data",  32'(bus.oCpuInstruction), 32'd0);
        checkOutput("rst_dbg_valid", 32'(bus.oDbgValid), 32'd0);
        checkOutput("rst_dbg_data",  32'(bus.oDbgInstruction), 32'd0);
        checkOutput("rst_dbg_done",  32'(bus.oDbgDone), 32'd0);
        checkOutput("rst_rom_addr",  32'(bus.oRomAddress), 32'd0);
        checkOutput("rst_grants",    32'({bus.oCpuGrant, bus.oDbgGrant}), 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        logic        cp, dp;
        logic [15:0] ca, da;

        $display("[TB] rom_fetch_arbiter bench start");
        doReset(1'b0);

        // Both requesting right after reset: CPU first, debug when the CPU drops.
        clearObs();
        repeat (3) applyStimulus(1'b1, 16'h0100, 1'b1, 16'h0200);
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0200);
        repeat (4) applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("first_grant_is_cpu", 32'(grantLog[0]), 32'd1);
        checkOutput("dbg_grant_when_cpu_drops", 32'(grantLog[3]), 32'd2);
        checkOutput("cpu_grants_before_dbg", 32'(cpuGntCount), 32'd3);
        wantQ = {28'h200, 28'h201, 28'h202, 28'h203};
        checkSeq("burst_after_cpu", obsDbg, wantQ);

        // CPU alone at 1, 2, 3.
        clearObs();
        applyStimulus(1'b1, 16'h0001, 1'b0, 16'h0000);
        applyStimulus(1'b1, 16'h0002, 1'b0, 16'h0000);
        applyStimulus(1'b1, 16'h0003, 1'b0, 16'h0000);
        repeat (2) applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        wantQ = {28'h1, 28'h2, 28'h3};
        checkSeq("cpu_only", obsCpu, wantQ);
        checkOutput("cpu_only_no_dbg", 32'(obsDbg.size()), 32'd0);

        // Debug alone at 0x0010.
        clearObs();
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0010);
        repeat (5) applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("dbg_grant_pulses", 32'(dbgGntCount), 32'd1);
        wantQ = {28'h10, 28'h11, 28'h12, 28'h13};
        checkSeq("dbg_only", obsDbg, wantQ);
        wantQ = {28'h13};
        checkSeq("dbg_done_word", obsDone, wantQ);

        // Burst across the top of the address space.
        clearObs();
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'hFFFE);
        repeat (5) applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        wantQ = {28'hFFFE, 28'hFFFF, 28'h0, 28'h1};
        checkSeq("dbg_wrap", obsDbg, wantQ);

        // Both held high: 8 CPU grants, a burst, repeat.
        clearObs();
        for (int i = 0; i < 36; i++) applyStimulus(1'b1, 16'(16'h0500 + i), 1'b1, 16'h4000);
        repeat (5) applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("fair_cpu_grants", 32'(cpuGntCount), 32'd24);
        checkOutput("fair_dbg_grants", 32'(dbgGntCount), 32'd3);
        checkOutput("fair_first_dbg_slot", 32'(grantLog[8]), 32'd2);
        checkOutput("fair_second_dbg_slot", 32'(grantLog[20]), 32'd2);

        // Reset after the second beat of a burst.
        clearObs();
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0030);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        doReset(1'b1);
        applyStimulus(1'b1, 16'h0005, 1'b0, 16'h0000);
        repeat (4) applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        wantQ = {28'h30, 28'h31};
        checkSeq("aborted_burst", obsDbg, wantQ);
        checkOutput("aborted_no_done", 32'(obsDone.size()), 32'd0);
        wantQ = {28'h5};
        checkSeq("post_reset_cpu", obsCpu, wantQ);

        // Random requesters that hold until granted.
        cp = 1'b0; dp = 1'b0; ca = 16'd0; da = 16'd0;
        for (int i = 0; i < 400; i++) begin
            if (!cp && $urandom_range(0, 1) == 1) begin
                cp = 1'b1;
                ca = 16'($urandom);
            end
            if (!dp && $urandom_range(0, 3) == 0) begin
                dp = 1'b1;
                da = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            end
            applyStimulus(cp, ca, dp, da);
            if (lastCpuGnt) cp = 1'b0;
            if (lastDbgGnt) dp = 1'b0;
            if (i == 250) begin
                doReset(1'b1);
                cp = 1'b0;
                dp = 1'b0;
            end
        end
        repeat (6) applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
